fft_8_out_reorder: RTL and testbench

//  Sink-side companion to the 8-point FFT processor. Captures the processor's output pairs
//  (X1 = bin k, X2 = bin k+4, one pair per clock while in_valid) in bit-reversed pair order.

---
 rtl/fft_8_out_reorder.sv | 152 +++++++++++++++
 tb/tb_fft_8_out_reorder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fft_8_out_reorder.sv
// Output reorder buffer for the 8-point FFT: captures bit-reversed X1/X2 pairs into a
// two-bank ping-pong store and streams each frame out in natural bin order 0..7.
module fft_8_out_reorder #(
    parameter int W = 16
) (
    input  logic                c,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] x1r,
    input  logic signed [W-1:0] x1i,
    input  logic signed [W-1:0] x2r,
    input  logic signed [W-1:0] x2i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] yr,
    output logic signed [W-1:0] yi,
    output logic [2:0]          out_idx,
    output logic                out_last,
    output logic                overflow
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Pair p carries bin rev2(p) in X1 and bin rev2(p)+4 in X2.
    function automatic logic [1:0] rev2(input logic [1:0] p);
        return {p[0], p[1]};
    endfunction

    logic signed [W-1:0] mem_re_r [16];
    logic signed [W-1:0] mem_im_r [16];

    state_t      state_r, state_s;
    logic [1:0]  full_r, full_s;
    logic [1:0]  pair_r;
    logic        wr_bank_r;
    logic        rd_bank_r, rd_bank_s;
    logic [2:0]  idx_s;
    logic        valid_s;
    logic        load_s;
    logic        wr_accept_s;
    logic        wr_set_s;
    logic        hs_s;
    logic        last_hs_s;

    // Write-side acceptance and next-cycle bank occupancy (drop test uses pre-update flags).
    always_comb begin
        wr_accept_s = in_valid && !full_r[wr_bank_r];
        wr_set_s    = wr_accept_s && (pair_r == 2'd3);
        hs_s        = out_valid && out_ready;
        last_hs_s   = hs_s && (out_idx == 3'd7);
        full_s[0]   = (full_r[0] && !(last_hs_s && !rd_bank_r)) || (wr_set_s && !wr_bank_r);
        full_s[1]   = (full_r[1] && !(last_hs_s &&  rd_bank_r)) || (wr_set_s &&  wr_bank_r);
    end

    // Read FSM: next state, next output beat and whether to load new bin data.
    always_comb begin
        state_s   = state_r;
        rd_bank_s = rd_bank_r;
        idx_s     = out_idx;
        valid_s   = out_valid;
        load_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (full_s[rd_bank_r]) begin
                    state_s = DRAIN;
                    valid_s = 1'b1;
                    idx_s   = 3'd0;
                    load_s  = 1'b1;
                end else begin
                    valid_s = 1'b0;
                end
            end
            DRAIN: begin
                if (hs_s) begin
                    if (out_idx == 3'd7) begin
                        rd_bank_s = !rd_bank_r;
                        idx_s     = 3'd0;
                        // The other bank may have filled this very cycle; continue without a bubble.
                        if (full_s[!rd_bank_r]) begin
                            valid_s = 1'b1;
                            load_s  = 1'b1;
                        end else begin
                            state_s = IDLE;
                            valid_s = 1'b0;
                        end
                    end else begin
                        idx_s  = out_idx + 3'd1;
                        load_s = 1'b1;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                idx_s   = 3'd0;
            end
        endcase
    end

    // Sample storage; content is qualified by the full flags, so it needs no reset.
    always_ff @(posedge c) begin
        if (wr_accept_s) begin
            mem_re_r[{wr_bank_r, 1'b0, rev2(pair_r)}] <= x1r;
            mem_im_r[{wr_bank_r, 1'b0, rev2(pair_r)}] <= x1i;
            mem_re_r[{wr_bank_r, 1'b1, rev2(pair_r)}] <= x2r;
            mem_im_r[{wr_bank_r, 1'b1, rev2(pair_r)}] <= x2i;
        end
    end

    // Control state, bank bookkeeping and registered outputs.
    always_ff @(posedge c) begin
        if (rst) begin
            state_r   <= IDLE;
            full_r    <= 2'b00;
            pair_r    <= 2'd0;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= 3'd0;
            out_last  <= 1'b0;
            yr        <= '0;
            yi        <= '0;
        end else begin
            state_r   <= state_s;
            full_r    <= full_s;
            rd_bank_r <= rd_bank_s;
            out_valid <= valid_s;
            out_idx   <= idx_s;
            out_last  <= valid_s && (idx_s == 3'd7);
            if (wr_accept_s) begin
                pair_r <= pair_r + 2'd1;
            end
            if (wr_set_s) begin
                wr_bank_r <= !wr_bank_r;
            end
            if (in_valid && full_r[wr_bank_r]) begin
                overflow <= 1'b1;
            end
            if (load_s) begin
                yr <= mem_re_r[{rd_bank_s, idx_s}];
                yi <= mem_im_r[{rd_bank_s, idx_s}];
            end
        end
    end

endmodule

// File: tb/tb_fft_8_out_reorder.sv
// Directed bench for fft_8_out_reorder: frames are tagged so that bin b of frame f carries
// (f*1000 + b*100, -(f*16 + b)), which makes order, duplication and loss all visible.
module tb_fft_8_out_reorder;

    localparam int W = 16;

    logic                c = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] x1r = '0, x1i = '0, x2r = '0, x2i = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] yr, yi;
    logic [2:0]          out_idx;
    logic                out_last;
    logic                overflow;

    int checks = 0;
    int failures = 0;

    fft_8_out_reorder #(.W(W)) dut (
        .c(c), .rst(rst), .in_valid(in_valid),
        .x1r(x1r), .x1i(x1i), .x2r(x2r), .x2i(x2i),
        .out_valid(out_valid), .out_ready(out_ready),
        .yr(yr), .yi(yi), .out_idx(out_idx), .out_last(out_last), .overflow(overflow)
    );

    always #5 c = ~c;

    function automatic logic signed [W-1:0] tag_re(input int f, input int b);
        return 16'(f * 1000 + b * 100);
    endfunction

    function automatic logic signed [W-1:0] tag_im(input int f, input int b);
        return 16'(-(f * 16 + b));
    endfunction

    task automatic step();
        @(posedge c);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pair p carries bins {0,4},{2,6},{1,5},{3,7} for p = 0..3.
    task automatic drive_pair(input int f, input int p);
        int k;
        k = ((p & 1) << 1) | ((p >> 1) & 1);
        in_valid = 1'b1;
        x1r = tag_re(f, k);
        x1i = tag_im(f, k);
        x2r = tag_re(f, k + 4);
        x2i = tag_im(f, k + 4);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        x1r = '0; x1i = '0; x2r = '0; x2i = '0;
    endtask

    task automatic send_frame(input int f);
        for (int p = 0; p < 4; p++) begin
            drive_pair(f, p);
            step();
        end
        idle_in();
    endtask

    task automatic check_beat(input int f, input int b);
        check("beat_valid", 32'(out_valid), 32'd1);
        check("beat_idx", 32'(out_idx), 32'(b));
        check("beat_yr", 32'(yr), 32'(tag_re(f, b)));
        check("beat_yi", 32'(yi), 32'(tag_im(f, b)));
        check("beat_last", 32'(out_last), (b == 7) ? 32'd1 : 32'd0);
    endtask

    task automatic expect_frame(input int f);
        for (int b = 0; b < 8; b++) begin
            check_beat(f, b);
            step();
        end
    endtask

    initial begin
        int beat;
        int cyc;

        // Reset held for three cycles.
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_yr", 32'(yr), 32'd0);
        check("rst_yi", 32'(yi), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Single frame, consumer always ready; valid must rise right after the 4th pair.
        out_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            drive_pair(0, p);
            step();
        end
        check("pre_valid", 32'(out_valid), 32'd0);
        drive_pair(0, 3);
        step();
        idle_in();
        expect_frame(0);
        check("single_end_valid", 32'(out_valid), 32'd0);

        // Backpressure: ready pattern 1,0,0 repeating; stalled beats must hold steady.
        send_frame(0);
        beat = 0;
        cyc = 0;
        while (beat < 8 && cyc < 60) begin
            out_ready = (cyc % 3 == 0);
            check_beat(0, beat);
            step();
            if (out_ready) beat++;
            cyc++;
        end
        check("bp_all_beats", 32'(beat), 32'd8);
        check("bp_end_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // Ping-pong: frame B written while A drains, 16 contiguous beats.
        send_frame(1);
        for (int i = 0; i < 16; i++) begin
            if (i < 4) drive_pair(2, i);
            else idle_in();
            check_beat(i < 8 ? 1 : 2, i % 8);
            step();
        end
        check("pp_end_valid", 32'(out_valid), 32'd0);
        check("pp_ovf", 32'(overflow), 32'd0);

        // Overflow: three frames back-to-back with the consumer stalled.
        out_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin drive_pair(3, p); step(); end
        for (int p = 0; p < 4; p++) begin drive_pair(4, p); step(); end
        check("ovf_before", 32'(overflow), 32'd0);
        for (int p = 0; p < 4; p++) begin drive_pair(5, p); step(); end
        idle_in();
        check("ovf_set", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        expect_frame(3);
        expect_frame(4);
        check("ovf_end_valid", 32'(out_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset during the 2nd pair of a frame.
        drive_pair(6, 0);
        step();
        drive_pair(6, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_in();
        check("rst1_valid", 32'(out_valid), 32'd0);
        check("rst1_ovf", 32'(overflow), 32'd0);
        send_frame(7);
        expect_frame(7);
        check("rst1_end_valid", 32'(out_valid), 32'd0);

        // Reset while presenting out_idx 3.
        send_frame(8);
        for (int b = 0; b < 3; b++) begin
            check_beat(8, b);
            step();
        end
        check_beat(8, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_valid", 32'(out_valid), 32'd0);
        check("rst2_idx", 32'(out_idx), 32'd0);
        check("rst2_yr", 32'(yr), 32'd0);
        check("rst2_last", 32'(out_last), 32'd0);
        step();
        check("rst2_still_idle", 32'(out_valid), 32'd0);
        send_frame(9);
        expect_frame(9);
        check("rst2_end_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
